// File: rtl/config_frame_loader_if.sv
// Valid/ready word stream into the configuration loader.
interface config_frame_loader_if #(
    parameter int SER_WIDTH = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [SER_WIDTH-1:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/config_frame_loader.sv
// Deserialises a SYNC/address/data word stream into frames and holds them as
// Q/QN configuration bits for the tile's switch-matrix and LUT muxes.
//
// state  | meaning
// IDLE   | waiting for SYNC_WORD, all other words dropped
// ADDR   | session open, next word is a frame address or END_ADDR
// DATA   | shifting FRAME_BITS/SER_WIDTH words into the frame register
// COMMIT | one-cycle bubble writing the frame into storage, s_ready low
module config_frame_loader #(
    parameter int                   FRAME_BITS = 32,
    parameter int                   FRAMES     = 20,
    parameter int                   SER_WIDTH  = 8,
    parameter logic [SER_WIDTH-1:0] SYNC_WORD  = 8'hA5,
    parameter logic [SER_WIDTH-1:0] END_ADDR   = '1
) (
    input  logic                         CLK,
    input  logic                         resetn,
    config_frame_loader_if.slave         s_if,
    output logic [FRAMES*FRAME_BITS-1:0] o_cfg_q,
    output logic [FRAMES*FRAME_BITS-1:0] o_cfg_qn,
    output logic                         o_cfg_active,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int                   WORDS    = FRAME_BITS / SER_WIDTH;
    localparam int                   CW       = $clog2(WORDS + 1);
    localparam logic [CW-1:0]        LAST_CNT = CW'(WORDS - 1);
    localparam logic [SER_WIDTH-1:0] FRAMES_W = SER_WIDTH'(FRAMES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_cnt;
    logic [SER_WIDTH-1:0]        r_addr;
    logic                        r_discard;
    logic [FRAME_BITS-1:0]       r_sr;
    logic [FRAMES*FRAME_BITS-1:0] r_store;
    logic                        r_ready;
    logic                        r_active;
    logic                        r_done;
    logic                        r_err;
    logic                        w_accept;

    assign w_accept     = s_if.s_valid & r_ready;
    assign s_if.s_ready = r_ready;
    assign o_cfg_q      = r_store;
    assign o_cfg_qn     = ~r_store;
    assign o_cfg_active = r_active;
    assign o_done       = r_done;
    assign o_err        = r_err;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_discard <= 1'b0;
            r_sr      <= '0;
            r_store   <= '0;
            r_ready   <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && s_if.s_data == SYNC_WORD) begin
                        r_state  <= ADDR;
                        r_active <= 1'b1;
                        r_err    <= 1'b0;
                    end
                end
                ADDR: begin
                    if (w_accept) begin
                        if (s_if.s_data == END_ADDR) begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            // Out-of-range frames are still consumed so the stream stays aligned.
                            r_state   <= DATA;
                            r_cnt     <= '0;
                            r_discard <= (s_if.s_data >= FRAMES_W);
                            if (s_if.s_data >= FRAMES_W) begin
                                r_err <= 1'b1;
                            end else begin
                                r_addr <= s_if.s_data;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_sr  <= {r_sr[FRAME_BITS-SER_WIDTH-1:0], s_if.s_data};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= COMMIT;
                            r_ready <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    if (!r_discard) begin
                        for (int f = 0; f < FRAMES; f++) begin
                            if (r_addr == SER_WIDTH'(f)) begin
                                r_store[f*FRAME_BITS +: FRAME_BITS] <= r_sr;
                            end
                        end
                    end
                    r_state <= ADDR;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader with a per-frame expected-value model.
module tb_config_frame_loader;

    localparam int FB = 32;
    localparam int NF = 20;
    localparam int TW = FB * NF;

    logic          CLK;
    logic          resetn;
    logic [TW-1:0] cfg_q;
    logic [TW-1:0] cfg_qn;
    logic          cfg_active;
    logic          done;
    logic          err;

    config_frame_loader_if #(.SER_WIDTH(8)) s_if ();

    config_frame_loader dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .s_if         (s_if),
        .o_cfg_q      (cfg_q),
        .o_cfg_qn     (cfg_qn),
        .o_cfg_active (cfg_active),
        .o_done       (done),
        .o_err        (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int qn_bad = 0;
    int rdy_low = 0;
    int done_cnt = 0;
    logic [FB-1:0] exp_frame [NF];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (cfg_qn !== ~cfg_q) qn_bad++;
        if (resetn) begin
            if (!s_if.s_ready) rdy_low++;
            if (done) done_cnt++;
        end
    end

    function automatic logic [TW-1:0] model_vec();
        logic [TW-1:0] v;
        for (int f = 0; f < NF; f++) v[f*FB +: FB] = exp_frame[f];
        return v;
    endfunction

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        s_if.s_data  = d;
        s_if.s_valid = 1'b1;
        @(negedge CLK);
        while (!s_if.s_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout word=%h s_ready stayed 0", d);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        s_if.s_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] w);
        send(a);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    endtask

    task automatic check_store(input string name);
        n_cmp++;
        if (cfg_q !== model_vec()) begin
            n_bad++;
            $display("FAIL %s cfg_q got=%h exp=%h", name, cfg_q, model_vec());
        end
    endtask

    task automatic test_reset();
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        resetn = 1'b0;
        for (int f = 0; f < NF; f++) exp_frame[f] = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_store("reset_q");
        n_cmp++; if (cfg_qn !== {TW{1'b1}}) begin n_bad++; $display("FAIL reset_qn got=%h exp=all ones", cfg_qn); end
        n_cmp++; if (s_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", s_if.s_ready); end
        n_cmp++; if (cfg_active !== 1'b0) begin n_bad++; $display("FAIL reset_active got=%b exp=0", cfg_active); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        #3 resetn = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_single_frame();
        int r0, d0;
        r0 = rdy_low;
        d0 = done_cnt;
        send(8'hA5);
        n_cmp++; if (cfg_active !== 1'b1) begin n_bad++; $display("FAIL single_active_rise got=%b exp=1", cfg_active); end
        send_frame(8'h03, 32'hDEADBEEF);
        exp_frame[3] = 32'hDEADBEEF;
        send(8'hFF);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done_pulse got=%b exp=1", done); end
        n_cmp++; if (cfg_active !== 1'b0) begin n_bad++; $display("FAIL single_active_fall got=%b exp=0", cfg_active); end
        idle(1);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_width got=%b exp=0", done); end
        check_store("single_frame");
        n_cmp++; if (cfg_q[127:96] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_frame3 got=%h exp=deadbeef", cfg_q[127:96]); end
        n_cmp++; if (rdy_low - r0 !== 1) begin n_bad++; $display("FAIL single_ready_bubble got=%0d exp=1", rdy_low - r0); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_multi_stall();
        logic [31:0] w [2];
        logic [7:0]  a [2];
        w[0] = 32'h12345678; a[0] = 8'd0;
        w[1] = 32'h89ABCDEF; a[1] = 8'd19;
        idle($urandom_range(0, 2));
        send(8'hA5);
        for (int k = 0; k < 2; k++) begin
            idle($urandom_range(0, 3));
            send(a[k]);
            for (int i = 3; i >= 0; i--) begin
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
                send(w[k][i*8 +: 8]);
            end
            exp_frame[a[k]] = w[k];
        end
        idle(2);
        check_store("multi_mid_session");
        n_cmp++; if (cfg_active !== 1'b1) begin n_bad++; $display("FAIL multi_active_hold got=%b exp=1", cfg_active); end
        send(8'hFF);
        idle(1);
        check_store("multi_stall");
    endtask

    task automatic test_bad_addr();
        send(8'hA5);
        send(8'h14);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_err_rise got=%b exp=1", err); end
        for (int i = 0; i < 4; i++) send(8'h77);
        send_frame(8'h05, 32'h11223344);
        exp_frame[5] = 32'h11223344;
        send(8'hFF);
        idle(2);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_err_sticky got=%b exp=1", err); end
        check_store("bad_addr");
    endtask

    task automatic test_noise();
        int d0;
        d0 = done_cnt;
        send(8'h00);
        send(8'h5A);
        send(8'hFF);
        idle(2);
        n_cmp++; if (cfg_active !== 1'b0) begin n_bad++; $display("FAIL noise_active got=%b exp=0", cfg_active); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL noise_done got=%0d exp=0", done_cnt - d0); end
        check_store("noise_store");
        send(8'hA5);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL sync_clears_err got=%b exp=0", err); end
        send(8'hFF);
        idle(1);
    endtask

    task automatic test_reset_mid_frame();
        send(8'hA5);
        send_frame(8'h07, 32'hCAFEF00D);
        exp_frame[7] = 32'hCAFEF00D;
        send(8'hFF);
        idle(1);
        check_store("pre_reset_frame7");
        send(8'hA5);
        send(8'h07);
        send(8'hCA);
        send(8'hFE);
        #2 resetn = 1'b0;
        s_if.s_valid = 1'b0;
        for (int f = 0; f < NF; f++) exp_frame[f] = '0;
        #1;
        check_store("mid_reset_clear");
        n_cmp++; if (cfg_active !== 1'b0) begin n_bad++; $display("FAIL mid_reset_active got=%b exp=0", cfg_active); end
        n_cmp++; if (s_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready got=%b exp=1", s_if.s_ready); end
        @(posedge CLK);
        #3 resetn = 1'b1;
        @(posedge CLK); #1;
        send(8'hA5);
        send_frame(8'h07, 32'h0BADC0DE);
        send_frame(8'h02, 32'hA5A5A5A5);
        exp_frame[7] = 32'h0BADC0DE;
        exp_frame[2] = 32'hA5A5A5A5;
        send(8'hFF);
        idle(2);
        check_store("post_reset_session");
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL post_reset_err got=%b exp=0", err); end
    endtask

    task automatic test_qn_always();
        n_cmp++; if (qn_bad !== 0) begin n_bad++; $display("FAIL qn_complement bad_cycles=%0d exp=0", qn_bad); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_multi_stall();
        test_bad_addr();
        test_noise();
        test_reset_mid_frame();
        test_qn_always();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
